// File: rtl/activation_tanh_arbiter_if.sv
// Bundle of requester, activation-unit and response signals for activation_tanh_arbiter.
// TANH_ARB_STATS_EN adds the grant_cnt/stall_cnt statistics outputs.
interface activation_tanh_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         act_data_o;
    logic                          act_valid_o;
    logic [DATA_WIDTH-1:0]         act_data_i;
    logic                          act_valid_i;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic                          tag_err;
`ifdef TANH_ARB_STATS_EN
    logic [31:0]                   grant_cnt;
    logic [31:0]                   stall_cnt;
`endif

    modport slave (
        input  req_valid, req_data, act_data_i, act_valid_i, rsp_ready,
`ifdef TANH_ARB_STATS_EN
        output grant_cnt, stall_cnt,
`endif
        output req_ready, act_data_o, act_valid_o, rsp_valid, rsp_data, tag_err
    );

    modport master (
        output req_valid, req_data, act_data_i, act_valid_i, rsp_ready,
`ifdef TANH_ARB_STATS_EN
        input  grant_cnt, stall_cnt,
`endif
        input  req_ready, act_data_o, act_valid_o, rsp_valid, rsp_data, tag_err
    );
endinterface

// File: rtl/activation_tanh_arbiter.sv
// Round-robin arbiter sharing one tanh activation unit among NUM_REQ requesters, with a tag
// pipeline routing results back. Define TANH_ARB_STATS_EN to add grant/stall counters.
module activation_tanh_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACT_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    activation_tanh_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [NUM_REQ-1:0]            r_outstanding;
    logic [NUM_REQ-1:0]            r_rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] r_rsp_data;
    logic [IDX_W-1:0]              r_last_grant;
    logic                          r_tag_err;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [NUM_REQ-1:0] w_rsp_accept;
    logic               w_grant_vld;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_rsp_write;
    logic               w_tag_mismatch;
    tag_t               w_tag_in;
    tag_t               w_tag_out;

    assign w_eligible = bus.req_valid & ~r_outstanding;

    // Search upward from the requester after the last winner.
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_cand = IDX_W'((int'(r_last_grant) + k) % int'(NUM_REQ));
            if (!w_grant_vld && w_eligible[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_grant_oh = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_tag_in   = {w_grant_vld, w_grant_idx};

    generate
        if (ACT_LATENCY == 0) begin : g_tag_comb
            assign w_tag_out = w_tag_in;
        end else begin : g_tag_pipe
            tag_t r_tag [ACT_LATENCY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < int'(ACT_LATENCY); k++) r_tag[k] <= '0;
                end else begin
                    r_tag[0] <= w_tag_in;
                    for (int k = 1; k < int'(ACT_LATENCY); k++) r_tag[k] <= r_tag[k-1];
                end
            end
            assign w_tag_out = r_tag[ACT_LATENCY-1];
        end
    endgenerate

    assign w_rsp_accept   = r_rsp_valid & bus.rsp_ready;
    assign w_tag_mismatch = bus.act_valid_i != w_tag_out.valid;
    assign w_rsp_write    = bus.act_valid_i & w_tag_out.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_last_grant  <= IDX_W'(NUM_REQ - 1);
            r_tag_err     <= 1'b0;
        end else begin
            r_outstanding <= (r_outstanding & ~w_rsp_accept) | w_grant_oh;
            r_rsp_valid   <= r_rsp_valid & ~w_rsp_accept;
            if (w_grant_vld) r_last_grant <= w_grant_idx;
            if (w_tag_mismatch) r_tag_err <= 1'b1;
            // Target slot is free: its owner is outstanding, so rsp_valid there is low.
            if (w_rsp_write) begin
                r_rsp_valid[w_tag_out.idx] <= 1'b1;
                r_rsp_data[w_tag_out.idx*DATA_WIDTH +: DATA_WIDTH] <= bus.act_data_i;
            end
        end
    end

`ifdef TANH_ARB_STATS_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant_vld) r_grant_cnt <= r_grant_cnt + 32'd1;
            if (|bus.req_valid && !w_grant_vld) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.grant_cnt = r_grant_cnt;
    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.req_ready   = w_grant_oh;
    assign bus.act_valid_o = w_grant_vld;
    assign bus.act_data_o  = w_grant_vld ?
                             bus.req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.tag_err     = r_tag_err;
endmodule
